// File: rtl/dsp19x2_fir_seq_pkg.sv
// Shared types and constants for the DSP19X2 FIR sequencer.
//   state_t              : sequencer FSM states
//   FEEDBACK_COEFF_BASE  : FEEDBACK code that selects COEFFx_0
//   B_W / Z_W / MAX_TAPS : sample width, result width, delay-line depth
//   coeff_sel()          : FEEDBACK code for a given tap index
package dsp19x2_fir_seq_pkg;

  localparam int B_W      = 9;
  localparam int Z_W      = 19;
  localparam int MAX_TAPS = 4;

  localparam logic [2:0] FEEDBACK_COEFF_BASE = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // FEEDBACK = 3'b1kk picks COEFFx_kk inside the primitive
  function automatic logic [2:0] coeff_sel(input logic [1:0] tap);
    return FEEDBACK_COEFF_BASE | {1'b0, tap};
  endfunction

endpackage

// File: rtl/dsp19x2_fir_sequencer_if.sv
// Bus bundle between the FIR sequencer, its sample source/result sink and
// the DSP19X2 primitive.
//   slave  : sequencer side (accepts samples, produces results, drives DSP)
//   master : environment side (sample source, result sink, DSP primitive)
interface dsp19x2_fir_sequencer_if;
  import dsp19x2_fir_seq_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [B_W-1:0]   s_data1;
  logic [B_W-1:0]   s_data2;
  logic             m_valid;
  logic             m_ready;
  logic [Z_W-1:0]   m_data1;
  logic [Z_W-1:0]   m_data2;
  logic [B_W-1:0]   dsp_b1;
  logic [B_W-1:0]   dsp_b2;
  logic [2:0]       dsp_feedback;
  logic             dsp_load_acc;
  logic             dsp_round;
  logic [4:0]       dsp_shift_right;
  logic [Z_W-1:0]   dsp_z1;
  logic [Z_W-1:0]   dsp_z2;
  logic             busy;

  modport slave (
    input  s_valid, s_data1, s_data2, m_ready, dsp_z1, dsp_z2,
    output s_ready, m_valid, m_data1, m_data2, dsp_b1, dsp_b2,
           dsp_feedback, dsp_load_acc, dsp_round, dsp_shift_right, busy
  );

  modport master (
    output s_valid, s_data1, s_data2, m_ready, dsp_z1, dsp_z2,
    input  s_ready, m_valid, m_data1, m_data2, dsp_b1, dsp_b2,
           dsp_feedback, dsp_load_acc, dsp_round, dsp_shift_right, busy
  );

endinterface

// File: rtl/dsp19x2_fir_seq_dline.sv
// Two-lane sample delay line, MAX_TAPS deep.
//   clk, rst      : clock, asynchronous active-high reset (clears every tap)
//   shift_en      : push din1/din2 into tap 0, older samples move up one tap
//   din1, din2    : incoming lane samples
//   rd_sel        : tap index for the read port
//   rd1, rd2      : selected tap, combinational
module dsp19x2_fir_seq_dline
  import dsp19x2_fir_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           shift_en,
  input  logic [B_W-1:0] din1,
  input  logic [B_W-1:0] din2,
  input  logic [1:0]     rd_sel,
  output logic [B_W-1:0] rd1,
  output logic [B_W-1:0] rd2
);

  logic [B_W-1:0] lane1_r [MAX_TAPS];
  logic [B_W-1:0] lane2_r [MAX_TAPS];

  // Shift register for both lanes; holds when no sample is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_TAPS; i++) begin
        lane1_r[i] <= {B_W{1'b0}};
        lane2_r[i] <= {B_W{1'b0}};
      end
    end else if (shift_en) begin
      lane1_r[0] <= din1;
      lane2_r[0] <= din2;
      for (int i = 1; i < MAX_TAPS; i++) begin
        lane1_r[i] <= lane1_r[i-1];
        lane2_r[i] <= lane2_r[i-1];
      end
    end else begin
      for (int i = 0; i < MAX_TAPS; i++) begin
        lane1_r[i] <= lane1_r[i];
        lane2_r[i] <= lane2_r[i];
      end
    end
  end

  assign rd1 = lane1_r[rd_sel];
  assign rd2 = lane2_r[rd_sel];

endmodule

// File: rtl/dsp19x2_fir_sequencer.sv
// Control stage in front of a DSP19X2 dual 10x9 MAC, running it as a
// two-lane NUM_TAPS-tap FIR. Holds the sample delay line, issues one tap per
// cycle on B/FEEDBACK/LOAD_ACC, waits out the DSP pipeline, then presents the
// Z1/Z2 result on a valid/ready output.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave modport of dsp19x2_fir_sequencer_if (sample input,
//              result output, DSP drive/return, busy)
// Optional build macro DSP19X2_FIR_SEQUENCER_ROUND_EN: when defined, ROUND=1
// and SHIFT_RIGHT=SHIFT are driven to the DSP; otherwise both are 0.
module dsp19x2_fir_sequencer
  import dsp19x2_fir_seq_pkg::*;
#(
  parameter int NUM_TAPS    = 4,
  parameter int DSP_LATENCY = 1,
  parameter int SHIFT       = 0
) (
  input logic                    clk,
  input logic                    rst,
  dsp19x2_fir_sequencer_if.slave bus
);

`ifdef DSP19X2_FIR_SEQUENCER_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif
  localparam logic [4:0] SHIFT_CFG = ROUND_EN ? 5'(SHIFT) : 5'd0;
  localparam logic [1:0] LAST_TAP  = 2'(NUM_TAPS - 1);
  localparam logic [3:0] LAST_LAT  = 4'(DSP_LATENCY - 1);

  state_t         state_r, state_next_s;
  logic [1:0]     k_r, k_next_s;
  logic [3:0]     lat_r, lat_next_s;
  logic           s_ready_r, s_ready_next_s;
  logic           m_valid_r, m_valid_next_s;
  logic [Z_W-1:0] m_data1_r, m_data1_next_s;
  logic [Z_W-1:0] m_data2_r, m_data2_next_s;
  logic [B_W-1:0] b1_r, b1_next_s;
  logic [B_W-1:0] b2_r, b2_next_s;
  logic [2:0]     fb_r, fb_next_s;
  logic           load_r, load_next_s;
  logic           busy_r, busy_next_s;
  logic           round_r;
  logic [4:0]     shift_r;
  logic           shift_en_s;
  logic [B_W-1:0] tap1_s, tap2_s;

  // DSP drive is registered, so the read port looks one tap ahead of k_r
  dsp19x2_fir_seq_dline u_dline (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en_s),
    .din1     (bus.s_data1),
    .din2     (bus.s_data2),
    .rd_sel   (k_r + 2'd1),
    .rd1      (tap1_s),
    .rd2      (tap2_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_next_s   = state_r;
    k_next_s       = k_r;
    lat_next_s     = lat_r;
    s_ready_next_s = s_ready_r;
    m_valid_next_s = m_valid_r;
    m_data1_next_s = m_data1_r;
    m_data2_next_s = m_data2_r;
    b1_next_s      = {B_W{1'b0}};
    b2_next_s      = {B_W{1'b0}};
    fb_next_s      = 3'b000;
    load_next_s    = 1'b0;
    shift_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.s_valid && s_ready_r) begin
          // Tap 0 is the sample being accepted right now
          shift_en_s     = 1'b1;
          s_ready_next_s = 1'b0;
          k_next_s       = 2'd0;
          b1_next_s      = bus.s_data1;
          b2_next_s      = bus.s_data2;
          fb_next_s      = coeff_sel(2'd0);
          load_next_s    = 1'b1;
          state_next_s   = MAC;
        end else begin
          s_ready_next_s = 1'b1;
        end
      end
      MAC: begin
        if (k_r == LAST_TAP) begin
          lat_next_s   = 4'd0;
          state_next_s = DRAIN;
        end else begin
          k_next_s  = k_r + 2'd1;
          b1_next_s = tap1_s;
          b2_next_s = tap2_s;
          fb_next_s = coeff_sel(k_r + 2'd1);
        end
      end
      DRAIN: begin
        if (lat_r == LAST_LAT) begin
          m_data1_next_s = bus.dsp_z1;
          m_data2_next_s = bus.dsp_z2;
          m_valid_next_s = 1'b1;
          state_next_s   = HOLD;
        end else begin
          lat_next_s = lat_r + 4'd1;
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          m_valid_next_s = 1'b0;
          s_ready_next_s = 1'b1;
          state_next_s   = IDLE;
        end else begin
          m_valid_next_s = 1'b1;
        end
      end
      default: begin
        state_next_s   = IDLE;
        s_ready_next_s = 1'b0;
        m_valid_next_s = 1'b0;
      end
    endcase
    busy_next_s = (state_next_s != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      k_r       <= 2'd0;
      lat_r     <= 4'd0;
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
      m_data1_r <= {Z_W{1'b0}};
      m_data2_r <= {Z_W{1'b0}};
      b1_r      <= {B_W{1'b0}};
      b2_r      <= {B_W{1'b0}};
      fb_r      <= 3'b000;
      load_r    <= 1'b0;
      busy_r    <= 1'b0;
      round_r   <= 1'b0;
      shift_r   <= 5'd0;
    end else begin
      state_r   <= state_next_s;
      k_r       <= k_next_s;
      lat_r     <= lat_next_s;
      s_ready_r <= s_ready_next_s;
      m_valid_r <= m_valid_next_s;
      m_data1_r <= m_data1_next_s;
      m_data2_r <= m_data2_next_s;
      b1_r      <= b1_next_s;
      b2_r      <= b2_next_s;
      fb_r      <= fb_next_s;
      load_r    <= load_next_s;
      busy_r    <= busy_next_s;
      round_r   <= ROUND_EN;
      shift_r   <= SHIFT_CFG;
    end
  end

  assign bus.s_ready         = s_ready_r;
  assign bus.m_valid         = m_valid_r;
  assign bus.m_data1         = m_data1_r;
  assign bus.m_data2         = m_data2_r;
  assign bus.dsp_b1          = b1_r;
  assign bus.dsp_b2          = b2_r;
  assign bus.dsp_feedback    = fb_r;
  assign bus.dsp_load_acc    = load_r;
  assign bus.dsp_round       = round_r;
  assign bus.dsp_shift_right = shift_r;
  assign bus.busy            = busy_r;

endmodule

// File: tb/tb_dsp19x2_fir_sequencer.sv
// Bench for dsp19x2_fir_sequencer: unit 0 is the default 4-tap/latency-1
// build (SHIFT=3), unit 1 is a 2-tap/latency-2 build. Each unit drives a
// behavioural DSP19X2 model; results are checked against an FIR computed
// from a per-unit sample history and coefficient table.
module tb_dsp19x2_fir_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dsp19x2_fir_sequencer_if bus_a ();
  dsp19x2_fir_sequencer_if bus_b ();

  dsp19x2_fir_sequencer #(.NUM_TAPS(4), .DSP_LATENCY(1), .SHIFT(3)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  dsp19x2_fir_sequencer #(.NUM_TAPS(2), .DSP_LATENCY(2), .SHIFT(0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  // Per-unit stimulus and observation
  logic        s_valid_t [2];
  logic [8:0]  s_d1_t [2], s_d2_t [2];
  logic        m_ready_t [2];
  logic        s_ready_o [2], m_valid_o [2], busy_o [2], load_o [2], round_o [2];
  logic [18:0] m1_o [2], m2_o [2];
  logic [8:0]  b1_o [2], b2_o [2];
  logic [2:0]  fb_o [2];
  logic [4:0]  shr_o [2];

  assign bus_a.s_valid = s_valid_t[0];  assign bus_b.s_valid = s_valid_t[1];
  assign bus_a.s_data1 = s_d1_t[0];     assign bus_b.s_data1 = s_d1_t[1];
  assign bus_a.s_data2 = s_d2_t[0];     assign bus_b.s_data2 = s_d2_t[1];
  assign bus_a.m_ready = m_ready_t[0];  assign bus_b.m_ready = m_ready_t[1];
  assign s_ready_o[0] = bus_a.s_ready;  assign s_ready_o[1] = bus_b.s_ready;
  assign m_valid_o[0] = bus_a.m_valid;  assign m_valid_o[1] = bus_b.m_valid;
  assign busy_o[0]    = bus_a.busy;     assign busy_o[1]    = bus_b.busy;
  assign load_o[0]    = bus_a.dsp_load_acc; assign load_o[1] = bus_b.dsp_load_acc;
  assign round_o[0]   = bus_a.dsp_round;    assign round_o[1] = bus_b.dsp_round;
  assign shr_o[0]     = bus_a.dsp_shift_right; assign shr_o[1] = bus_b.dsp_shift_right;
  assign m1_o[0] = bus_a.m_data1;  assign m1_o[1] = bus_b.m_data1;
  assign m2_o[0] = bus_a.m_data2;  assign m2_o[1] = bus_b.m_data2;
  assign b1_o[0] = bus_a.dsp_b1;   assign b1_o[1] = bus_b.dsp_b1;
  assign b2_o[0] = bus_a.dsp_b2;   assign b2_o[1] = bus_b.dsp_b2;
  assign fb_o[0] = bus_a.dsp_feedback; assign fb_o[1] = bus_b.dsp_feedback;

  // DSP19X2 model: coefficient registers, accumulator behind an output
  // register, and one extra pipeline stage for the latency-2 unit
  int coef1 [4], coef2 [4];
  logic signed [31:0] acc1 [2], acc2 [2], dly1 [2], dly2 [2];

  // Behavioural MAC of the primitive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        acc1[u] <= 0; acc2[u] <= 0; dly1[u] <= 0; dly2[u] <= 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (fb_o[u][2]) begin
          if (load_o[u]) begin
            acc1[u] <= coef1[fb_o[u][1:0]] * int'($signed(b1_o[u]));
            acc2[u] <= coef2[fb_o[u][1:0]] * int'($signed(b2_o[u]));
          end else begin
            acc1[u] <= acc1[u] + coef1[fb_o[u][1:0]] * int'($signed(b1_o[u]));
            acc2[u] <= acc2[u] + coef2[fb_o[u][1:0]] * int'($signed(b2_o[u]));
          end
        end
        dly1[u] <= acc1[u];
        dly2[u] <= acc2[u];
      end
    end
  end

  assign bus_a.dsp_z1 = acc1[0][18:0];
  assign bus_a.dsp_z2 = acc2[0][18:0];
  assign bus_b.dsp_z1 = dly1[1][18:0];
  assign bus_b.dsp_z2 = dly2[1][18:0];

  // Tap issue log: load_acc*8 + feedback for every cycle something is issued
  int log0 [$], log1 [$];
  always @(posedge clk) begin
    if (!rst) begin
      if (fb_o[0] != 3'd0 || load_o[0]) log0.push_back(int'(load_o[0]) * 8 + int'(fb_o[0]));
      if (fb_o[1] != 3'd0 || load_o[1]) log1.push_back(int'(load_o[1]) * 8 + int'(fb_o[1]));
    end
  end

  function automatic int log_size(input int u);
    return (u == 0) ? log0.size() : log1.size();
  endfunction

  function automatic int log_at(input int u, input int i);
    if (i >= log_size(u)) return -1;
    return (u == 0) ? log0[i] : log1[i];
  endfunction

  // Reference: sample history per unit, newest first
  int h1 [2][4], h2 [2][4];
  int n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 4; k++) begin h1[u][k] = 0; h2[u][k] = 0; end
  endtask

  task automatic chk_zero(input int u);
    check_eq("rst_s_ready", int'(s_ready_o[u]), 0);
    check_eq("rst_m_valid", int'(m_valid_o[u]), 0);
    check_eq("rst_busy",    int'(busy_o[u]), 0);
    check_eq("rst_m_data1", int'(m1_o[u]), 0);
    check_eq("rst_m_data2", int'(m2_o[u]), 0);
    check_eq("rst_b1",      int'(b1_o[u]), 0);
    check_eq("rst_b2",      int'(b2_o[u]), 0);
    check_eq("rst_fb",      int'(fb_o[u]), 0);
    check_eq("rst_load",    int'(load_o[u]), 0);
    check_eq("rst_round",   int'(round_o[u]), 0);
    check_eq("rst_shift",   int'(shr_o[u]), 0);
  endtask

  task automatic chk_round(input int u);
`ifdef DSP19X2_FIR_SEQUENCER_ROUND_EN
    check_eq("round", int'(round_o[u]), 1);
    check_eq("shift_right", int'(shr_o[u]), (u == 0) ? 3 : 0);
`else
    check_eq("round", int'(round_o[u]), 0);
    check_eq("shift_right", int'(shr_o[u]), 0);
`endif
  endtask

  // One full transaction; hold=0 keeps m_ready high throughout, otherwise
  // the result is back-pressured for 'hold' cycles with stray s_valid pulses
  task automatic run_tx(input int u, input int d1, input int d2, input int hold,
                        output int got1, output int got2);
    int nt, lt, cnt, e1, e2;
    nt = (u == 0) ? 4 : 2;
    lt = (u == 0) ? 1 : 2;
    got1 = 0; got2 = 0;
    if (u == 0) log0.delete(); else log1.delete();
    m_ready_t[u] = (hold == 0);
    @(negedge clk);
    s_valid_t[u] = 1'b1; s_d1_t[u] = 9'(d1); s_d2_t[u] = 9'(d2);
    cnt = 0;
    while (!s_ready_o[u] && cnt < 20) begin @(negedge clk); cnt++; end
    check_eq("s_ready_wait", int'(s_ready_o[u]), 1);
    for (int k = 3; k > 0; k--) begin h1[u][k] = h1[u][k-1]; h2[u][k] = h2[u][k-1]; end
    h1[u][0] = d1; h2[u][0] = d2;
    e1 = 0; e2 = 0;
    for (int k = 0; k < nt; k++) begin
      e1 += coef1[k] * h1[u][k];
      e2 += coef2[k] * h2[u][k];
    end
    @(posedge clk); #1;
    s_valid_t[u] = 1'b0;
    check_eq("busy_after_accept", int'(busy_o[u]), 1);
    check_eq("s_ready_after_accept", int'(s_ready_o[u]), 0);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!m_valid_o[u] && cnt < 40);
    check_eq("latency", cnt, nt + lt + 1);
    got1 = int'($signed(m1_o[u]));
    got2 = int'($signed(m2_o[u]));
    check_eq("m_data1", got1, e1);
    check_eq("m_data2", got2, e2);
    check_eq("tap_count", log_size(u), nt);
    for (int i = 0; i < nt; i++)
      check_eq("tap_issue", log_at(u, i), ((i == 0) ? 8 : 0) + 4 + i);
    for (int i = 0; i < hold; i++) begin
      s_valid_t[u] = i[0];
      s_d1_t[u] = 9'($urandom); s_d2_t[u] = 9'($urandom);
      @(negedge clk);
      check_eq("bp_m_valid", int'(m_valid_o[u]), 1);
      check_eq("bp_m_data1", int'($signed(m1_o[u])), e1);
      check_eq("bp_m_data2", int'($signed(m2_o[u])), e2);
      check_eq("bp_s_ready", int'(s_ready_o[u]), 0);
    end
    s_valid_t[u] = 1'b0;
    m_ready_t[u] = 1'b1;
    @(posedge clk); #1;
    m_ready_t[u] = 1'b0;
    check_eq("done_m_valid", int'(m_valid_o[u]), 0);
    check_eq("done_s_ready", int'(s_ready_o[u]), 1);
    check_eq("done_busy", int'(busy_o[u]), 0);
  endtask

  task automatic set_fixed_coefs();
    coef1 = '{1, 2, 3, 4};
    coef2 = '{10, 20, 30, 40};
  endtask

  task automatic impulse_step();
    int g1, g2;
    int step_exp [4];
    step_exp = '{-10, -30, -60, -100};
    for (int i = 0; i < 4; i++) begin
      run_tx(0, (i == 0) ? 1 : 0, -1, 0, g1, g2);
      check_eq("impulse_lane1", g1, i + 1);
      check_eq("step_lane2", g2, step_exp[i]);
    end
  endtask

  initial begin
    int g1, g2;
    for (int u = 0; u < 2; u++) begin
      s_valid_t[u] = 1'b0; s_d1_t[u] = 9'd0; s_d2_t[u] = 9'd0; m_ready_t[u] = 1'b0;
    end
    set_fixed_coefs();
    clear_hist();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero(0); chk_zero(1);
    rst = 1'b0;
    #1;
    check_eq("s_ready_before_edge", int'(s_ready_o[0]), 0);
    @(posedge clk); #1;
    check_eq("s_ready_after_edge", int'(s_ready_o[0]), 1);
    chk_round(0); chk_round(1);

    impulse_step();

    // Back-pressure with stray s_valid pulses, then a result that depends on
    // the delay line being untouched by them
    run_tx(0, 5, -3, 6, g1, g2);
    run_tx(0, 0, 0, 0, g1, g2);

    // Random coefficients and samples on both units
    for (int k = 0; k < 4; k++) begin
      coef1[k] = int'($urandom_range(0, 127)) - 64;
      coef2[k] = int'($urandom_range(0, 127)) - 64;
    end
    for (int i = 0; i < 8; i++)
      run_tx(0, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
             int'($urandom_range(0, 3)), g1, g2);
    for (int i = 0; i < 6; i++)
      run_tx(1, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
             int'($urandom_range(0, 3)), g1, g2);

    // Reset during the second MAC cycle
    set_fixed_coefs();
    @(negedge clk);
    s_valid_t[0] = 1'b1; s_d1_t[0] = 9'd77; s_d2_t[0] = 9'd12;
    @(posedge clk); #1;
    s_valid_t[0] = 1'b0;
    check_eq("pre_abort_busy", int'(busy_o[0]), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_zero(0);
    clear_hist();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_s_ready_low", int'(s_ready_o[0]), 0);
    @(posedge clk); #1;
    check_eq("abort_s_ready_high", int'(s_ready_o[0]), 1);
    chk_round(0);
    impulse_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
